// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM write-only management port of the PLL reconfig IP.
// master drives the write strobe, address and data; slave returns waitrequest.
interface pll_reconfig_seq_if;
   logic        cfg_waitrequest;
   logic        cfg_write;
   logic [5:0]  cfg_address;
   logic [31:0] cfg_data;

   modport master (
      input  cfg_waitrequest,
      output cfg_write,
      output cfg_address,
      output cfg_data
   );

   modport slave (
      output cfg_waitrequest,
      input  cfg_write,
      input  cfg_address,
      input  cfg_data
   );
endinterface

// File: rtl/pll_reconfig_seq.sv
// PLL reconfig sequencer: on a model/TV-system change writes mode, K and start, then waits for relock.
// Optional PLLRECONF_RETRY_EN: rerun the write sequence up to 3 times on lock timeout before flagging error.
module pll_reconfig_seq #(
   parameter logic [31:0] K_PAL        = 32'd1503512573,
   parameter logic [31:0] K_NTSC       = 32'd3357876127,
   parameter logic [31:0] K_BIZ        = 32'd2233385555,
   parameter int          LOCK_SETTLE  = 16,
   parameter int          LOCK_TIMEOUT = 1000000
) (
   input  logic                      CLK_50M,
   input  logic                      RESET,
   input  logic                      model,
   input  logic                      ntsc,
   input  logic                      pll_locked,
   pll_reconfig_seq_if.master        cfg,
   output logic                      busy,
   output logic [1:0]                profile,
   output logic                      error
);
   localparam int SW = $clog2(LOCK_SETTLE + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, W_MODE, W_K, W_START, GAP, WAIT_LOCK} state_t;

   state_t         state_q, state_d;
   logic           model_s1_q, model_s2_q, ntsc_s1_q, ntsc_s2_q, lock_s1_q, lock_s2_q;
   logic           model_r_q, model_r_d, ntsc_r_q, ntsc_r_d;
   logic           pending_q, pending_d;
   logic [31:0]    k_q, k_d;
   logic [1:0]     tgt_q, tgt_d;
   logic [5:0]     addr_q, addr_d;
   logic [31:0]    data_q, data_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [SW-1:0]  settle_q, settle_d;
   logic [1:0]     profile_q, profile_d;
   logic           error_q, error_d;
`ifdef PLLRECONF_RETRY_EN
   logic [1:0]     retry_q, retry_d;
`endif

   logic           wr;
   logic [5:0]     wr_addr;
   logic [31:0]    wr_data;
   logic           pend_set, pend_clr;
   logic [31:0]    k_target;
   logic [1:0]     tgt_target;

   assign k_target   = model_r_q ? K_BIZ : (ntsc_r_q ? K_NTSC : K_PAL);
   assign tgt_target = model_r_q ? 2'd2  : (ntsc_r_q ? 2'd1   : 2'd0);

   always_ff @(posedge CLK_50M) begin
      if (RESET) begin
         state_q    <= IDLE;
         model_s1_q <= 1'b0;
         model_s2_q <= 1'b0;
         ntsc_s1_q  <= 1'b0;
         ntsc_s2_q  <= 1'b0;
         lock_s1_q  <= 1'b0;
         lock_s2_q  <= 1'b0;
         model_r_q  <= 1'b0;
         ntsc_r_q   <= 1'b0;
         pending_q  <= 1'b0;
         k_q        <= '0;
         tgt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         tmo_q      <= '0;
         settle_q   <= '0;
         profile_q  <= '0;
         error_q    <= 1'b0;
`ifdef PLLRECONF_RETRY_EN
         retry_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         model_s1_q <= model;
         model_s2_q <= model_s1_q;
         ntsc_s1_q  <= ntsc;
         ntsc_s2_q  <= ntsc_s1_q;
         lock_s1_q  <= pll_locked;
         lock_s2_q  <= lock_s1_q;
         model_r_q  <= model_r_d;
         ntsc_r_q   <= ntsc_r_d;
         pending_q  <= pending_d;
         k_q        <= k_d;
         tgt_q      <= tgt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         tmo_q      <= tmo_d;
         settle_q   <= settle_d;
         profile_q  <= profile_d;
         error_q    <= error_d;
`ifdef PLLRECONF_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      model_r_d = model_r_q;
      ntsc_r_d  = ntsc_r_q;
      k_d       = k_q;
      tgt_d     = tgt_q;
      tmo_d     = tmo_q;
      settle_d  = settle_q;
      profile_d = profile_q;
      error_d   = error_q;
`ifdef PLLRECONF_RETRY_EN
      retry_d   = retry_q;
`endif
      wr        = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;

      // ntsc only matters to the PLL while the Business model is not selected
      if (model_s2_q == model_s1_q && model_s2_q != model_r_q) begin
         model_r_d = model_s2_q;
         pend_set  = 1'b1;
      end
      if (ntsc_s2_q == ntsc_s1_q && ntsc_s2_q != ntsc_r_q) begin
         ntsc_r_d = ntsc_s2_q;
         if (!model_r_q) pend_set = 1'b1;
      end

      case (state_q)
         IDLE: begin
`ifdef PLLRECONF_RETRY_EN
            retry_d = '0;
`endif
            if (pending_q) begin
               pend_clr = 1'b1;
               k_d      = k_target;
               tgt_d    = tgt_target;
               state_d  = W_MODE;
            end
         end
         W_MODE: if (!cfg.cfg_waitrequest) begin
            wr      = 1'b1;
            wr_addr = 6'd0;
            wr_data = 32'd0;
            state_d = GAP;
         end
         W_K: if (!cfg.cfg_waitrequest) begin
            wr      = 1'b1;
            wr_addr = 6'd7;
            wr_data = k_q;
            state_d = GAP;
         end
         W_START: if (!cfg.cfg_waitrequest) begin
            wr       = 1'b1;
            wr_addr  = 6'd2;
            wr_data  = 32'd0;
            tmo_d    = '0;
            settle_d = '0;
            state_d  = WAIT_LOCK;
         end
         // the address just written tells which write comes next
         GAP: state_d = (addr_q == 6'd0) ? W_K : W_START;
         WAIT_LOCK: begin
            tmo_d    = tmo_q + TW'(1);
            settle_d = lock_s2_q ? settle_q + SW'(1) : '0;
            if (lock_s2_q && settle_q == SW'(LOCK_SETTLE - 1)) begin
               profile_d = tgt_q;
               error_d   = 1'b0;
               state_d   = IDLE;
            end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
`ifdef PLLRECONF_RETRY_EN
               if (retry_q == 2'd3) begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  retry_d = retry_q + 2'd1;
                  state_d = W_MODE;
               end
`else
               error_d = 1'b1;
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      pending_d = pend_set ? 1'b1 : (pend_clr ? 1'b0 : pending_q);
      addr_d    = wr ? wr_addr : addr_q;
      data_d    = wr ? wr_data : data_q;
   end

   assign cfg.cfg_write   = wr;
   assign cfg.cfg_address = wr ? wr_addr : addr_q;
   assign cfg.cfg_data    = wr ? wr_data : data_q;
   assign busy            = (state_q != IDLE);
   assign profile         = profile_q;
   assign error           = error_q;
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq; lock timeout shortened so both build variants finish quickly.
module tb_pll_reconfig_seq;
   localparam logic [31:0] K_PAL  = 32'd1503512573;
   localparam logic [31:0] K_NTSC = 32'd3357876127;
   localparam logic [31:0] K_BIZ  = 32'd2233385555;
   localparam int          TMO    = 300;
`ifdef PLLRECONF_RETRY_EN
   localparam int          NSEQ   = 4;
`else
   localparam int          NSEQ   = 1;
`endif

   logic       CLK_50M = 1'b0;
   logic       RESET, model, ntsc, pll_locked;
   logic       busy, error;
   logic [1:0] profile;
   int         tests = 0;
   int         fails = 0;
   int         wr_count = 0;
   int         wc0, seen;

   pll_reconfig_seq_if ifc ();

   pll_reconfig_seq #(.LOCK_TIMEOUT(TMO)) dut (
      .CLK_50M    (CLK_50M),
      .RESET      (RESET),
      .model      (model),
      .ntsc       (ntsc),
      .pll_locked (pll_locked),
      .cfg        (ifc),
      .busy       (busy),
      .profile    (profile),
      .error      (error)
   );

   always #10 CLK_50M = ~CLK_50M;

   always @(posedge CLK_50M) if (ifc.cfg_write === 1'b1) wr_count <= wr_count + 1;

   task automatic tick();
      @(negedge CLK_50M);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_write(input string tag, input logic [5:0] a, input logic [31:0] d, input int bound);
      int n = 0;
      do begin
         tick();
         n++;
      end while (ifc.cfg_write !== 1'b1 && n < bound);
      chk({tag, " strobe"}, ifc.cfg_write, 1);
      chk({tag, " addr"}, ifc.cfg_address, a);
      chk({tag, " data"}, ifc.cfg_data, d);
   endtask

   task automatic seq_writes(input string tag, input logic [31:0] k, input int bound);
      expect_write({tag, " mode"}, 6'd0, 32'd0, bound);
      tick();
      chk({tag, " gap1"}, ifc.cfg_write, 0);
      expect_write({tag, " K"}, 6'd7, k, 1);
      tick();
      chk({tag, " gap2"}, ifc.cfg_write, 0);
      expect_write({tag, " start"}, 6'd2, 32'd0, 1);
   endtask

   task automatic lock_and_finish(input string tag, input logic [1:0] prof);
      pll_locked = 1'b1;
      repeat (17) tick();
      chk({tag, " busy before settle"}, busy, 1);
      tick();
      chk({tag, " busy after settle"}, busy, 0);
      chk({tag, " profile"}, profile, prof);
      chk({tag, " error"}, error, 0);
   endtask

   initial begin
      RESET = 1'b1;
      model = 1'b0;
      ntsc = 1'b0;
      pll_locked = 1'b1;
      ifc.cfg_waitrequest = 1'b0;
      repeat (3) tick();
      chk("reset cfg_write", ifc.cfg_write, 0);
      chk("reset cfg_address", ifc.cfg_address, 0);
      chk("reset cfg_data", ifc.cfg_data, 0);
      chk("reset busy", busy, 0);
      chk("reset profile", profile, 0);
      chk("reset error", error, 0);
      RESET = 1'b0;
      repeat (100) tick();
      chk("idle no writes", wr_count, 0);
      chk("idle busy", busy, 0);
      chk("idle profile", profile, 0);

      // PAL -> NTSC
      pll_locked = 1'b0;
      ntsc = 1'b1;
      seq_writes("ntsc", K_NTSC, 10);
      repeat (50) tick();
      chk("ntsc busy waiting", busy, 1);
      chk("ntsc profile held", profile, 0);
      lock_and_finish("ntsc", 2'd1);

      // Business model with waitrequest stalling the K write
      pll_locked = 1'b0;
      model = 1'b1;
      expect_write("biz mode", 6'd0, 32'd0, 10);
      tick();
      chk("biz gap1", ifc.cfg_write, 0);
      ifc.cfg_waitrequest = 1'b1;
      seen = 0;
      repeat (10) begin
         tick();
         if (ifc.cfg_write !== 1'b0) seen++;
      end
      chk("biz writes while waitrequest", seen, 0);
      chk("biz busy while stalled", busy, 1);
      ifc.cfg_waitrequest = 1'b0;
      #1;
      chk("biz K strobe", ifc.cfg_write, 1);
      chk("biz K addr", ifc.cfg_address, 7);
      chk("biz K data", ifc.cfg_data, K_BIZ);
      tick();
      chk("biz gap2", ifc.cfg_write, 0);
      expect_write("biz start", 6'd2, 32'd0, 1);
      repeat (5) tick();
      lock_and_finish("biz", 2'd2);

      // ntsc toggles while Business is selected are absorbed
      wc0 = wr_count;
      ntsc = 1'b0;
      repeat (10) tick();
      chk("biz ntsc0 busy", busy, 0);
      ntsc = 1'b1;
      repeat (10) tick();
      chk("biz ntsc toggle no writes", wr_count, wc0);
      chk("biz ntsc toggle busy", busy, 0);
      pll_locked = 1'b0;
      model = 1'b0;
      seq_writes("biz->ntsc", K_NTSC, 10);
      lock_and_finish("biz->ntsc", 2'd1);

      // change during WAIT_LOCK chains a second sequence
      pll_locked = 1'b0;
      ntsc = 1'b0;
      seq_writes("pal", K_PAL, 10);
      repeat (10) tick();
      ntsc = 1'b1;
      repeat (10) tick();
      lock_and_finish("pal", 2'd0);
      seq_writes("chain", K_NTSC, 1);
      repeat (16) tick();
      chk("chain busy before settle", busy, 1);
      tick();
      chk("chain busy after settle", busy, 0);
      chk("chain profile", profile, 1);

      // lock never returns
      wc0 = wr_count;
      pll_locked = 1'b0;
      ntsc = 1'b0;
      seq_writes("tmo", K_PAL, 10);
      for (int i = 0; i < NSEQ; i++) begin
         repeat (TMO) tick();
         chk("tmo busy before timeout", busy, 1);
         chk("tmo error before timeout", error, 0);
         if (i < NSEQ - 1) seq_writes("retry", K_PAL, 1);
      end
      tick();
      chk("tmo error", error, 1);
      chk("tmo busy", busy, 0);
      chk("tmo profile unchanged", profile, 1);
      chk("tmo write count", wr_count - wc0, 3 * NSEQ);

      // RESET while stalled in W_K
      ntsc = 1'b1;
      expect_write("rst mode", 6'd0, 32'd0, 10);
      tick();
      ifc.cfg_waitrequest = 1'b1;
      repeat (3) tick();
      chk("rst stalled busy", busy, 1);
      chk("rst stalled write", ifc.cfg_write, 0);
      RESET = 1'b1;
      tick();
      chk("rst busy", busy, 0);
      chk("rst error", error, 0);
      chk("rst profile", profile, 0);
      chk("rst cfg_write", ifc.cfg_write, 0);
      chk("rst cfg_address", ifc.cfg_address, 0);
      chk("rst cfg_data", ifc.cfg_data, 0);
      RESET = 1'b0;
      ifc.cfg_waitrequest = 1'b0;
      seq_writes("post-rst", K_NTSC, 10);
      lock_and_finish("post-rst", 2'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequences dynamic reconfiguration of the system PLL through the Avalon-MM management port of the PLL reconfig IP, in the CLK_50M domain.
- Syncs and debounces the model and TV-system selections, picks the fractional-K value for the target pixel clock, and issues the write sequence mode → K → start.
- Waits for PLL relock and reports busy, profile and error status to the core reset/status logic.

Parameters:
- K_PAL, 32'd1503512573, fractional K for PAL 31.527954 MHz profile
- K_NTSC, 32'd3357876127, fractional K for NTSC 32.727266 MHz profile
- K_BIZ, 32'd2233385555, fractional K for Business-model 32.000000 MHz profile
- LOCK_SETTLE, 16, consecutive pll_locked-high cycles required to declare lock
- LOCK_TIMEOUT, 1000000, cycles (20 ms) allowed from start write to lock

Ports:
- CLK_50M  in  1  management clock; all logic on rising edge
- RESET  in  1  synchronous, active-high
- model  in  1  async; 1 = Business model
- ntsc  in  1  async; 1 = NTSC
- pll_locked  in  1  async PLL lock
- cfg_waitrequest  in  1  reconfig IP waitrequest
- cfg_write  out  1  one-cycle write strobe
- cfg_address  out  6  register address
- cfg_data  out  32  write data
- busy  out  1  sequence in progress
- profile  out  2  applied profile: 0 = PAL, 1 = NTSC, 2 = BIZ
- error  out  1  last sequence failed to relock

Behaviour:
- Interface: reset RESET, synchronous, active-high; clock CLK_50M.
- Reset values:
  - cfg_write = 0, cfg_address = 0, cfg_data = 0, busy = 0, profile = 0, error = 0.
  - Applied model_r = 0, ntsc_r = 0; pending = 0; FSM = IDLE.
  - No writes are issued at reset; the PLL powers up in the PAL profile.
- Input sync: model, ntsc and pll_locked each pass through a 2-FF synchronizer (s1, s2).
  - A selection change is accepted only when s2 == s1 (two stable samples) and s2 differs from the applied value.
  - An accepted change updates model_r/ntsc_r and sets pending.
  - An ntsc change while model_r = 1 updates ntsc_r but does not set pending.
  - A model change always sets pending.
- Target: K = model_r ? K_BIZ : (ntsc_r ? K_NTSC : K_PAL). K is latched into k_r when leaving IDLE, so changes during a sequence do not corrupt it.
- FSM states: IDLE, W_MODE, W_K, W_START, GAP, WAIT_LOCK.
  - IDLE: if pending, clear pending, latch k_r, busy = 1, go to W_MODE.
  - W_MODE, W_K, W_START: issue a write only in a cycle with cfg_waitrequest = 0, as a single cycle of cfg_write = 1 with address/data valid the same cycle.
    - W_MODE writes addr 0, data 0 (waitrequest mode).
    - W_K writes addr 7, data k_r.
    - W_START writes addr 2, data 0.
    - After each write, one GAP cycle (cfg_write = 0), then the next write state. After W_START, go to WAIT_LOCK.
    - While cfg_waitrequest = 1 the FSM holds the state and cfg_write stays 0.
  - WAIT_LOCK: the timeout counter starts at 0 and the settle counter counts consecutive synced-lock-high cycles; a low sample clears settle.
    - Settle reaching LOCK_SETTLE: profile updates, error = 0, busy = 0, go to IDLE.
    - Timeout counter reaching LOCK_TIMEOUT: failure handling (see Optional Feature).
- Pending set during busy is retained; a new sequence starts from IDLE on the cycle after completion, using the newest applied values.
- Back-to-back toggles collapse: only the final stable value is sequenced.
- cfg_address and cfg_data hold their last value when cfg_write = 0.
- RESET mid-sequence: immediate return to reset values; the partial write sequence is abandoned. The PLL IP is expected to be reset by the same RESET.

Optional Feature:
- Macro: PLLRECONF_RETRY_EN.
- Defined: on lock timeout, the FSM reruns from W_MODE with the same k_r, up to 3 retries (2-bit retry counter, cleared in IDLE). After the 3rd timeout: error = 1, busy = 0, IDLE, profile unchanged.
- Undefined: the first timeout sets error = 1, busy = 0, IDLE, profile unchanged.
- In both cases error clears on the next successful lock.

Test Plan:
- Reset, model = 0, ntsc = 0 held 100 cycles → no cfg_write, busy = 0, profile = 0.
- ntsc 0→1, waitrequest = 0, pll_locked drops then rises after 50 cycles:
  - writes (0, 0), (7, 3357876127), (2, 0), each one cycle with one gap cycle between;
  - busy falls 16 cycles after lock;
  - profile = 1.
- model 0→1 with cfg_waitrequest held high 10 cycles at W_K → cfg_write stays 0 during those cycles; write (7, 2233385555) occurs on the first low cycle; profile = 2.
- model = 1, toggle ntsc → no writes; then model→0 with ntsc = 1 → sequence with K_NTSC.
- ntsc toggled during WAIT_LOCK → second sequence starts immediately after the first completes.
- pll_locked held low:
  - without PLLRECONF_RETRY_EN: error = 1 after 1000000 cycles;
  - with it: 4 full write sequences, then error = 1.
  - In both cases RESET asserted mid-W_K → all outputs 0 next cycle.
